ex_hazard_controller: RTL and testbench
=======================================

EX_HAZARD_CONTROLLER -- requirements
Module: ex_hazard_controller

Interface
REQ-001 Parameter MC_TIMEOUT, default 32; multicycle-wait cycle limit, legal range 2..255.
REQ-002 Parameter CHECK_R0, default 0; when 0, destination register 0 never raises a hazard.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 nreset  in  1  reset, asynchronous, active-low.
REQ-005 id_ex_instr  in  32  instruction entering EX.
REQ-006 id_ex_valid  in  1  id_ex_instr is a live instruction.
REQ-007 ex_mem_instr  in  32  instruction in EX/MEM.
REQ-008 ex_mem_is_load  in  1  EX/MEM instruction is a memory load.
REQ-009 mc_req  in  1  id_ex_instr needs the multicycle ALU path.
REQ-010 mc_done  in  1  multicycle unit result ready; 1-cycle pulse.
REQ-011 flush  in  1  taken branch; kill the EX instruction.
REQ-012 stall_if_id  out  1  hold the IF/ID register.
REQ-013 stall_id_ex  out  1  hold the ID/EX register.
REQ-014 bubble_ex  out  1  load a NOP into EX/MEM.
REQ-015 mc_start  out  1  1-cycle start pulse to the multicycle unit.
REQ-016 mc_abort  out  1  1-cycle abort pulse to the multicycle unit.
REQ-017 mc_timeout_err  out  1  sticky multicycle timeout flag.
REQ-018 stall_cycles  out  16  count of stalled cycles.

Function
REQ-019 Field decode: dest = instr[31:27]; src_top = instr[14:10]; src_bot = instr[9:5].
REQ-020 hazard = id_ex_valid & ex_mem_is_load & (ex_mem dest == id_ex src_top or src_bot) & (dest != 0 or CHECK_R0); combinational.
REQ-021 FSM states: IDLE, LOAD_STALL, MC_WAIT, MC_DRAIN; 2-bit encoding.
REQ-022 IDLE: priority is flush > hazard > mc_req.
REQ-023 IDLE with flush: bubble_ex=1, no stall, stay in IDLE.
REQ-024 IDLE with hazard: stall_if_id=stall_id_ex=bubble_ex=1 in the same cycle (Mealy); next state LOAD_STALL.
REQ-025 IDLE with id_ex_valid & mc_req and no hazard: mc_start=1 and both stalls=1 in the same cycle; next state MC_WAIT; wait counter cleared to 0.
REQ-026 LOAD_STALL: no outputs asserted (forwarding resolves the load); next state IDLE unconditionally; total load-use penalty is exactly 1 cycle.
REQ-027 MC_WAIT: both stalls=1, bubble_ex=1; wait counter increments each cycle.
REQ-028 MC_WAIT exits: flush -> mc_abort=1, next IDLE; else counter == MC_TIMEOUT-1 without mc_done -> mc_timeout_err set, mc_abort=1, next IDLE; else mc_done -> next MC_DRAIN.
REQ-029 flush and mc_done in the same MC_WAIT cycle: the flush abort wins, and the result is discarded.
REQ-030 MC_DRAIN: stalls=0, bubble_ex=0 (result enters EX/MEM); next state IDLE.
REQ-031 mc_done outside MC_WAIT is ignored.
REQ-032 mc_start and mc_abort are never high in the same cycle.
REQ-033 mc_timeout_err stays set until reset.

Reset
REQ-034 Asynchronous nreset low: state=IDLE, wait counter=0, mc_timeout_err=0, stall_cycles=0, all pulse outputs 0.
REQ-035 Reset during MC_WAIT: no mc_abort is issued; the multicycle unit is reset by the same nreset.

Configuration
REQ-036 Macro EX_HAZARD_PERF_EN defined: stall_cycles increments in every cycle where stall_id_ex=1, saturating at 16'hFFFF.
REQ-037 Macro EX_HAZARD_PERF_EN undefined: stall_cycles tied to 0, and no counter flops are present.

Structure
REQ-038 Shared package ex_hazard_pkg holds the state enum, field bit positions (dest/src_top/src_bot msb/lsb), and MC_TIMEOUT default.
REQ-039 One sub-module, ex_hazard_detect, holds the purely combinational comparator for REQ-020; the FSM, counters and outputs stay in the top module.

Verification
REQ-040 ex_mem load dest=5, id_ex src_top=5, valid -> stalls+bubble for 1 cycle, LOAD_STALL for 1 cycle, then normal flow; stall_cycles=1.
REQ-041 ex_mem load dest=0, src_bot=0, CHECK_R0=0 -> no stall; CHECK_R0=1 -> 1-cycle stall.
REQ-042 mc_req at cycle 0, mc_done at cycle 6 -> mc_start at cycle 0, stalls at cycles 0-6, MC_DRAIN at cycle 7, stall_cycles=7.
REQ-043 mc_req with no mc_done, MC_TIMEOUT=32 -> mc_abort and mc_timeout_err 32 cycles after mc_start; err stays high until nreset.
REQ-044 flush and mc_done in the same MC_WAIT cycle -> mc_abort=1, no MC_DRAIN, next state IDLE.
REQ-045 nreset pulsed low mid-MC_WAIT -> all outputs 0 asynchronously, IDLE after release, no mc_abort pulse.

Source files
------------

// File: rtl/ex_hazard_pkg.sv
// rtl/ex_hazard_pkg.sv - shared state encoding, instruction field positions and defaults
package ex_hazard_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MC_WAIT    = 2'd2,
    S_MC_DRAIN   = 2'd3
  } state_t;

  localparam int REG_W       = 5;
  localparam int DEST_MSB    = 31;
  localparam int DEST_LSB    = 27;
  localparam int SRC_TOP_MSB = 14;
  localparam int SRC_TOP_LSB = 10;
  localparam int SRC_BOT_MSB = 9;
  localparam int SRC_BOT_LSB = 5;

  localparam int MC_TIMEOUT_DEFAULT = 32;
  // Wide enough for the largest legal MC_TIMEOUT (255)
  localparam int WAIT_W = 8;

endpackage

// File: rtl/ex_hazard_if.sv
// rtl/ex_hazard_if.sv - pipeline-side signal bundle for the EX hazard controller
interface ex_hazard_if;

  logic [31:0] id_ex_instr;
  logic        id_ex_valid;
  logic [31:0] ex_mem_instr;
  logic        ex_mem_is_load;
  logic        mc_req;
  logic        mc_done;
  logic        flush;

  logic        stall_if_id;
  logic        stall_id_ex;
  logic        bubble_ex;
  logic        mc_start;
  logic        mc_abort;
  logic        mc_timeout_err;
  logic [15:0] stall_cycles;

  modport master (
    output id_ex_instr, id_ex_valid, ex_mem_instr, ex_mem_is_load, mc_req, mc_done, flush,
    input  stall_if_id, stall_id_ex, bubble_ex, mc_start, mc_abort, mc_timeout_err, stall_cycles
  );

  modport slave (
    input  id_ex_instr, id_ex_valid, ex_mem_instr, ex_mem_is_load, mc_req, mc_done, flush,
    output stall_if_id, stall_id_ex, bubble_ex, mc_start, mc_abort, mc_timeout_err, stall_cycles
  );

endinterface

// File: rtl/ex_hazard_detect.sv
// rtl/ex_hazard_detect.sv - combinational load-use comparator between EX/MEM dest and ID/EX sources
module ex_hazard_detect
  import ex_hazard_pkg::*;
#(
  parameter int CHECK_R0 = 0
) (
  input  logic [31:0] id_ex_instr,
  input  logic        id_ex_valid,
  input  logic [31:0] ex_mem_instr,
  input  logic        ex_mem_is_load,
  output logic        hazard
);

  logic [REG_W-1:0] dest;
  logic [REG_W-1:0] src_top;
  logic [REG_W-1:0] src_bot;
  logic             unused_fields;

  assign dest    = ex_mem_instr[DEST_MSB:DEST_LSB];
  assign src_top = id_ex_instr[SRC_TOP_MSB:SRC_TOP_LSB];
  assign src_bot = id_ex_instr[SRC_BOT_MSB:SRC_BOT_LSB];

  // Opcode/immediate bits play no part in the comparison
  assign unused_fields = ^{id_ex_instr, ex_mem_instr};

  assign hazard = id_ex_valid & ex_mem_is_load
                & ((dest == src_top) | (dest == src_bot))
                & ((dest != '0) | (CHECK_R0 != 0));

endmodule

// File: rtl/ex_hazard_controller.sv
// rtl/ex_hazard_controller.sv - EX stage stall/bubble FSM with multicycle ALU handshake; EX_HAZARD_PERF_EN adds stall counter
module ex_hazard_controller
  import ex_hazard_pkg::*;
#(
  parameter int MC_TIMEOUT = MC_TIMEOUT_DEFAULT,
  parameter int CHECK_R0   = 0
) (
  input  logic       clock,
  input  logic       nreset,
  ex_hazard_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              timeout_q;
  logic              timeout_hit;
  logic              hazard;

  ex_hazard_detect #(
    .CHECK_R0(CHECK_R0)
  ) u_detect (
    .id_ex_instr   (bus.id_ex_instr),
    .id_ex_valid   (bus.id_ex_valid),
    .ex_mem_instr  (bus.ex_mem_instr),
    .ex_mem_is_load(bus.ex_mem_is_load),
    .hazard        (hazard)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Outputs are Mealy and forced low while nreset is asserted
  always_comb begin
    state_next      = state;
    wait_cnt_next   = wait_cnt;
    timeout_hit     = 1'b0;
    bus.stall_if_id = 1'b0;
    bus.stall_id_ex = 1'b0;
    bus.bubble_ex   = 1'b0;
    bus.mc_start    = 1'b0;
    bus.mc_abort    = 1'b0;
    if (nreset) begin
      case (state)
        S_IDLE: begin
          if (bus.flush) begin
            bus.bubble_ex = 1'b1;
          end else if (hazard) begin
            bus.stall_if_id = 1'b1;
            bus.stall_id_ex = 1'b1;
            bus.bubble_ex   = 1'b1;
            state_next      = S_LOAD_STALL;
          end else if (bus.id_ex_valid && bus.mc_req) begin
            bus.mc_start    = 1'b1;
            bus.stall_if_id = 1'b1;
            bus.stall_id_ex = 1'b1;
            wait_cnt_next   = '0;
            state_next      = S_MC_WAIT;
          end
        end
        S_LOAD_STALL: begin
          state_next = S_IDLE;
        end
        S_MC_WAIT: begin
          bus.stall_if_id = 1'b1;
          bus.stall_id_ex = 1'b1;
          bus.bubble_ex   = 1'b1;
          wait_cnt_next   = wait_cnt + 1'b1;
          // A flush kills the EX instruction even if its result just arrived
          if (bus.flush) begin
            bus.mc_abort = 1'b1;
            state_next   = S_IDLE;
          end else if ((wait_cnt == WAIT_LAST) && !bus.mc_done) begin
            timeout_hit  = 1'b1;
            bus.mc_abort = 1'b1;
            state_next   = S_IDLE;
          end else if (bus.mc_done) begin
            state_next = S_MC_DRAIN;
          end
        end
        S_MC_DRAIN: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  assign bus.mc_timeout_err = timeout_q | timeout_hit;

`ifdef EX_HAZARD_PERF_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      stall_cnt <= '0;
    end else if (bus.stall_id_ex && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_ex_hazard_controller.sv
// tb/tb_ex_hazard_controller.sv - directed vector table plus multicycle sequences for ex_hazard_controller
module tb_ex_hazard_controller;

`ifdef EX_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic [31:0] id_ex_instr;
  logic        id_ex_valid;
  logic [31:0] ex_mem_instr;
  logic        ex_mem_is_load;
  logic        mc_req;
  logic        mc_done;
  logic        flush;

  always #5 clock = ~clock;

  ex_hazard_if if0 ();
  ex_hazard_if if1 ();

  assign if0.id_ex_instr    = id_ex_instr;
  assign if0.id_ex_valid    = id_ex_valid;
  assign if0.ex_mem_instr   = ex_mem_instr;
  assign if0.ex_mem_is_load = ex_mem_is_load;
  assign if0.mc_req         = mc_req;
  assign if0.mc_done        = mc_done;
  assign if0.flush          = flush;
  assign if1.id_ex_instr    = id_ex_instr;
  assign if1.id_ex_valid    = id_ex_valid;
  assign if1.ex_mem_instr   = ex_mem_instr;
  assign if1.ex_mem_is_load = ex_mem_is_load;
  assign if1.mc_req         = mc_req;
  assign if1.mc_done        = mc_done;
  assign if1.flush          = flush;

  ex_hazard_controller #(.MC_TIMEOUT(32), .CHECK_R0(0)) dut0 (
    .clock (clock),
    .nreset(nreset),
    .bus   (if0.slave)
  );

  ex_hazard_controller #(.MC_TIMEOUT(4), .CHECK_R0(1)) dut1 (
    .clock (clock),
    .nreset(nreset),
    .bus   (if1.slave)
  );

  // {stall_if_id, stall_id_ex, bubble_ex, mc_start, mc_abort}
  logic [4:0] out0;
  logic [4:0] out1;
  assign out0 = {if0.stall_if_id, if0.stall_id_ex, if0.bubble_ex, if0.mc_start, if0.mc_abort};
  assign out1 = {if1.stall_if_id, if1.stall_id_ex, if1.bubble_ex, if1.mc_start, if1.mc_abort};

  typedef struct {
    logic       valid;
    logic [4:0] ex_dest;
    logic [4:0] id_dest;
    logic [4:0] id_top;
    logic [4:0] id_bot;
    logic       is_load;
    logic       req;
    logic       fl;
    logic [4:0] exp0;
    logic [4:0] exp1;
  } vec_t;

  vec_t vecs[13];
  int   tests  = 0;
  int   failed = 0;

  function automatic logic [31:0] mk(input logic [4:0] d, input logic [4:0] t, input logic [4:0] b);
    return {d, 12'hA5C, t, b, 5'h1F};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_ex_instr    = 32'h0;
    id_ex_valid    = 1'b0;
    ex_mem_instr   = 32'h0;
    ex_mem_is_load = 1'b0;
    mc_req         = 1'b0;
    mc_done        = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_inputs();
    nreset = 1'b0;
    #1;
    nreset = 1'b1;
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  initial begin
    //            valid exd   idd   top   bot   load req fl  exp0      exp1
    vecs[0]  = '{1'b1, 5'd5, 5'd1, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
    vecs[1]  = '{1'b1, 5'd5, 5'd1, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0, 5'b11100, 5'b11100};
    vecs[2]  = '{1'b1, 5'd7, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 5'b11100, 5'b11100};
    vecs[3]  = '{1'b1, 5'd7, 5'd7, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000};
    vecs[4]  = '{1'b0, 5'd5, 5'd1, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000};
    vecs[5]  = '{1'b1, 5'd0, 5'd1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b11100};
    vecs[6]  = '{1'b1, 5'd0, 5'd1, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
    vecs[7]  = '{1'b1, 5'd5, 5'd1, 5'd5, 5'd3, 1'b1, 1'b0, 1'b1, 5'b00100, 5'b00100};
    vecs[8]  = '{1'b1, 5'd5, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 5'b11010, 5'b11010};
    vecs[9]  = '{1'b0, 5'd5, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000};
    vecs[10] = '{1'b1, 5'd5, 5'd1, 5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 5'b11100, 5'b11100};
    vecs[11] = '{1'b1, 5'd5, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 5'b00100, 5'b00100};
    vecs[12] = '{1'b1, 5'd31, 5'd31, 5'd30, 5'd29, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000};

    // Reset state, with live inputs that would otherwise start the multicycle unit
    clear_inputs();
    id_ex_valid = 1'b1;
    mc_req      = 1'b1;
    #3;
    check("reset_out0", {27'd0, out0}, 32'd0);
    check("reset_out1", {27'd0, out1}, 32'd0);
    check("reset_err", {31'd0, if0.mc_timeout_err}, 32'd0);
    check("reset_stall_cycles", {16'd0, if0.stall_cycles}, 32'd0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      id_ex_valid    = vecs[i].valid;
      id_ex_instr    = mk(vecs[i].id_dest, vecs[i].id_top, vecs[i].id_bot);
      ex_mem_instr   = mk(vecs[i].ex_dest, 5'd4, 5'd6);
      ex_mem_is_load = vecs[i].is_load;
      mc_req         = vecs[i].req;
      flush          = vecs[i].fl;
      #1;
      check($sformatf("vec%0d_dut0", i), {27'd0, out0}, {27'd0, vecs[i].exp0});
      check($sformatf("vec%0d_dut1", i), {27'd0, out1}, {27'd0, vecs[i].exp1});
      clear_inputs();
      nreset = 1'b0;
      #1;
      nreset = 1'b1;
    end

    // Load-use: one stall cycle, then LOAD_STALL with nothing asserted
    do_reset();
    next_cycle();
    id_ex_valid    = 1'b1;
    id_ex_instr    = mk(5'd1, 5'd5, 5'd3);
    ex_mem_instr   = mk(5'd5, 5'd0, 5'd0);
    ex_mem_is_load = 1'b1;
    #1 check("load_c0", {27'd0, out0}, 32'b11100);
    next_cycle();
    #1 check("load_c1_load_stall", {27'd0, out0}, 32'b00000);
    next_cycle();
    ex_mem_is_load = 1'b0;
    #1 check("load_c2_idle", {27'd0, out0}, 32'b00000);
    check("load_stall_cycles", {16'd0, if0.stall_cycles}, PERF ? 32'd1 : 32'd0);

    // Multicycle op completing at cycle 6, drained at cycle 7
    do_reset();
    next_cycle();
    id_ex_valid = 1'b1;
    id_ex_instr = mk(5'd2, 5'd3, 5'd4);
    mc_req      = 1'b1;
    #1 check("mc_c0_start", {27'd0, out0}, 32'b11010);
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      mc_req  = 1'b0;
      mc_done = (c == 6);
      #1 check($sformatf("mc_c%0d_wait", c), {27'd0, out0}, 32'b11100);
    end
    next_cycle();
    mc_done = 1'b0;
    #1 check("mc_c7_drain", {27'd0, out0}, 32'b00000);
    next_cycle();
    mc_done = 1'b1;
    #1 check("mc_c8_idle_done_ignored", {27'd0, out0}, 32'b00000);
    check("mc_stall_cycles", {16'd0, if0.stall_cycles}, PERF ? 32'd7 : 32'd0);
    next_cycle();
    mc_done = 1'b0;
    mc_req  = 1'b1;
    #1 check("mc_c9_restart_from_idle", {27'd0, out0}, 32'b11010);
    next_cycle();
    mc_req = 1'b0;
    flush  = 1'b1;
    #1 check("mc_c10_flush_abort", {27'd0, out0}, 32'b11101);

    // Timeout: dut0 limit 32, dut1 limit 4
    do_reset();
    next_cycle();
    id_ex_valid = 1'b1;
    id_ex_instr = mk(5'd2, 5'd3, 5'd4);
    mc_req      = 1'b1;
    #1 check("to_c0_start", {27'd0, out0}, 32'b11010);
    for (int c = 1; c <= 31; c++) begin
      next_cycle();
      mc_req = 1'b0;
      #1;
      check($sformatf("to_c%0d_dut0", c), {26'd0, out0, if0.mc_timeout_err}, {26'd0, 5'b11100, 1'b0});
      check($sformatf("to_c%0d_dut1", c), {30'd0, out1[0], if1.mc_timeout_err},
            {30'd0, (c == 4), (c >= 4)});
    end
    next_cycle();
    #1 check("to_c32_abort_err", {26'd0, out0, if0.mc_timeout_err}, {26'd0, 5'b11101, 1'b1});
    next_cycle();
    #1 check("to_c33_idle_err", {26'd0, out0, if0.mc_timeout_err}, {26'd0, 5'b00000, 1'b1});
    check("to_stall_cycles", {16'd0, if0.stall_cycles}, PERF ? 32'd33 : 32'd0);
    repeat (5) next_cycle();
    #1 check("to_err_sticky", {31'd0, if0.mc_timeout_err}, 32'd1);
    nreset = 1'b0;
    #1 check("to_err_cleared", {31'd0, if0.mc_timeout_err}, 32'd0);
    nreset = 1'b1;

    // flush and mc_done together: abort wins, no drain
    do_reset();
    next_cycle();
    id_ex_valid = 1'b1;
    id_ex_instr = mk(5'd2, 5'd3, 5'd4);
    mc_req      = 1'b1;
    #1 check("fd_c0_start", {27'd0, out0}, 32'b11010);
    next_cycle();
    mc_req = 1'b0;
    next_cycle();
    next_cycle();
    flush   = 1'b1;
    mc_done = 1'b1;
    #1 check("fd_c3_abort", {26'd0, out0, if0.mc_timeout_err}, {26'd0, 5'b11101, 1'b0});
    next_cycle();
    flush   = 1'b0;
    mc_done = 1'b0;
    mc_req  = 1'b1;
    #1 check("fd_c4_idle_not_drain", {27'd0, out0}, 32'b11010);
    next_cycle();
    mc_req = 1'b0;
    flush  = 1'b1;
    #1 check("fd_c5_flush_abort", {27'd0, out0}, 32'b11101);

    // Reset mid MC_WAIT: outputs drop at once, no abort pulse, IDLE after release
    do_reset();
    next_cycle();
    id_ex_valid = 1'b1;
    id_ex_instr = mk(5'd2, 5'd3, 5'd4);
    mc_req      = 1'b1;
    #1 check("rs_c0_start", {27'd0, out0}, 32'b11010);
    next_cycle();
    mc_req = 1'b0;
    #1 check("rs_c1_wait", {27'd0, out0}, 32'b11100);
    next_cycle();
    #1;
    mc_req = 1'b1;
    flush  = 1'b1;
    nreset = 1'b0;
    #1 check("rs_async_low", {27'd0, out0}, 32'd0);
    @(posedge clock);
    #1 check("rs_held_low", {27'd0, out0}, 32'd0);
    check("rs_stall_cycles", {16'd0, if0.stall_cycles}, 32'd0);
    next_cycle();
    flush  = 1'b0;
    nreset = 1'b1;
    #1 check("rs_idle_after_release", {27'd0, out0}, 32'b11010);
    next_cycle();
    mc_req = 1'b0;
    flush  = 1'b1;
    #1 check("rs_flush_abort", {27'd0, out0}, 32'b11101);
    next_cycle();
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
